// File: rtl/data_sched_pkg.sv
// Shared types and default sizing for the data_sched round-robin burst scheduler.
package data_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        REL  = 2'd2
    } state_e;

    localparam int NREQ_DEF  = 4;
    localparam int DW_DEF    = 4;
    localparam int BURST_DEF = 4;

endpackage

// File: rtl/data_sched_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward from last+1, with wrap.
module rr_pick #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_sched.sv
// Round-robin burst scheduler forwarding a shared data source to one requester at a time.
// Optional per-requester completed-burst counters are enabled with DATA_SCHED_STATS_EN.
module data_sched
    import data_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int DW    = DW_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [DW-1:0]   data,
    input  logic            data_vld,
    output logic [NREQ-1:0] gnt,
    output logic [DW-1:0]   dataout,
    output logic            dataout_vld,
    output logic            busy,
    output logic            done,
    output logic            abort,
    output state_e          dbg_state
`ifdef DATA_SCHED_STATS_EN
    ,
    output logic [NREQ*8-1:0] gnt_cnt
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(BURST + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            dvld_q, dvld_d;
    logic            done_q, done_d;
    logic            abort_q, abort_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    rr_pick #(.N(NREQ)) u_pick (
        .req  (req),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Withdrawal takes priority over a beat arriving in the same cycle, so that beat is dropped.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        beat_d  = beat_q;
        dout_d  = dout_q;
        dvld_d  = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    gidx_d  = pick_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (!req[gidx_q]) begin
                    gnt_d   = '0;
                    abort_d = 1'b1;
                    state_d = REL;
                end else if (data_vld) begin
                    dout_d = data;
                    dvld_d = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        gnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = REL;
                    end
                end
            end
            REL: begin
                last_d  = gidx_q;
                beat_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NREQ - 1);
            beat_q  <= '0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign gnt         = gnt_q;
    assign dataout     = dout_q;
    assign dataout_vld = dvld_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign abort       = abort_q;
    assign dbg_state   = state_q;

`ifdef DATA_SCHED_STATS_EN
    logic [7:0] cnt_q [NREQ];
    logic [7:0] cnt_d [NREQ];

    // done is high only in REL, where gidx_q still names the requester that finished.
    always_comb begin
        cnt_d = cnt_q;
        if (done_q && cnt_q[gidx_q] != 8'hFF) begin
            cnt_d[gidx_q] = cnt_q[gidx_q] + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        gnt_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_cnt[i*8 +: 8] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_data_sched.sv
// Bench for data_sched: burst driver, queue-based scoreboard with an independent monitor, random bursts.
module tb_data_sched;
    import data_sched_pkg::*;

    localparam int NREQ  = 4;
    localparam int DW    = 4;
    localparam int BURST = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [DW-1:0]   data;
    logic            data_vld;
    logic [NREQ-1:0] gnt;
    logic [DW-1:0]   dataout;
    logic            dataout_vld;
    logic            busy;
    logic            done;
    logic            abort;
    state_e          dbg_state;
`ifdef DATA_SCHED_STATS_EN
    logic [NREQ*8-1:0] gnt_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Scoreboard queues: forwarded data, grants, and end-of-burst kind {abort,done}.
    logic [DW-1:0]   exp_q[$];
    logic [NREQ-1:0] exp_gnt_q[$];
    logic [1:0]      exp_end_q[$];

    int m_last = NREQ - 1;
    int stat_m[NREQ];
    int vld_count = 0;
    logic [NREQ-1:0] prev_gnt = '0;
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    data_sched #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .data        (data),
        .data_vld    (data_vld),
        .gnt         (gnt),
        .dataout     (dataout),
        .dataout_vld (dataout_vld),
        .busy        (busy),
        .done        (done),
        .abort       (abort),
        .dbg_state   (dbg_state)
`ifdef DATA_SCHED_STATS_EN
        ,
        .gnt_cnt     (gnt_cnt)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // Reference rule: first requesting index strictly after the last winner, wrapping around.
    function automatic int rr_model(input logic [NREQ-1:0] r, input int lst);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(lst + k) % NREQ]) return (lst + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic expect_grant(input logic [NREQ-1:0] reqs, output int w);
        logic [NREQ-1:0] oh;
        w = rr_model(reqs, m_last);
        oh = '0;
        oh[w] = 1'b1;
        exp_gnt_q.push_back(oh);
        m_last = w;
    endtask

    task automatic wait_grant();
        int lat;
        lat = 0;
        @(negedge clk);
        while (gnt == '0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("gnt_latency", lat, 0);
    endtask

    // mode 0: random stalls, random data; 1: no stalls, data 1..BURST; 2: fixed stall pattern
    task automatic run_burst(input logic [NREQ-1:0] reqs, input int abort_after, input int mode);
        int w, beats, cyc;
        bit v, aborted;
        expect_grant(reqs, w);
        req = reqs;
        data_vld = 1'b0;
        wait_grant();
        beats = 0;
        cyc = 0;
        aborted = 1'b0;
        while (beats < BURST && cyc < 64) begin
            if (beats == abort_after) begin
                req = reqs & ~(NREQ'(1) << w);
                data_vld = 1'b1;
                data = DW'($urandom);
                exp_end_q.push_back(2'b10);
                aborted = 1'b1;
                @(negedge clk);
                break;
            end
            if (mode == 1) v = 1'b1;
            else if (mode == 2) v = (cyc < 6) ? pat[cyc] : 1'b1;
            else v = ($urandom_range(0, 3) != 0);
            data_vld = v;
            data = (mode == 1) ? DW'(beats + 1) : DW'($urandom);
            if (v) begin
                exp_q.push_back(data);
                beats++;
                if (beats == BURST) begin
                    exp_end_q.push_back(2'b01);
                    if (stat_m[w] < 255) stat_m[w]++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (!aborted && beats < BURST) fail_now("burst_stuck");
        req = '0;
        data_vld = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: compares every presented output against the scoreboard queues.
    initial begin : monitor
        forever begin
            @(negedge clk);
            check("busy_vs_state", busy, (gnt != '0) || done || abort);
            check("gnt_onehot", $onehot0(gnt), 1);
            if (dataout_vld) begin
                vld_count++;
                if (exp_q.size() == 0) fail_now("dataout_unexpected");
                else check("dataout", dataout, exp_q.pop_front());
            end
            if (gnt != '0 && prev_gnt == '0) begin
                if (exp_gnt_q.size() == 0) fail_now("gnt_unexpected");
                else check("gnt", gnt, exp_gnt_q.pop_front());
            end
            if (done || abort) begin
                if (exp_end_q.size() == 0) fail_now("end_unexpected");
                else check("end_kind", {abort, done}, exp_end_q.pop_front());
                check("rel_gnt_zero", gnt, 0);
                check("beats_left_at_end", exp_q.size(), 0);
            end
            prev_gnt = gnt;
        end
    end

    initial begin : stimulus
        int w, v0;
        logic [DW-1:0] d;
        rst = 1'b1;
        req = '0;
        data = '0;
        data_vld = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_dataout", dataout, 0);
        check("rst_dataout_vld", dataout_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_abort", abort, 0);
        check("rst_state", dbg_state, IDLE);
        rst = 1'b0;
        @(negedge clk);

        // Fairness with all requesting, including the wrap back to requester 0.
        repeat (5) run_burst(4'b1111, -1, 0);
        run_burst(4'b0001, -1, 1);

        v0 = vld_count;
        run_burst(4'b0001, -1, 2);
        check("stall_pulses", vld_count - v0, 4);

        run_burst(4'b0100, 2, 0);
        run_burst(4'b1001, -1, 0);
        run_burst(4'b0010, BURST - 1, 1);
        run_burst(4'b1000, 0, 0);

        // Reset in the middle of a burst, after its first beat.
        expect_grant(4'b0110, w);
        req = 4'b0110;
        wait_grant();
        d = DW'($urandom);
        data = d;
        data_vld = 1'b1;
        exp_q.push_back(d);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        data_vld = 1'b0;
        @(negedge clk);
        check("midrst_gnt", gnt, 0);
        check("midrst_dataout", dataout, 0);
        check("midrst_dataout_vld", dataout_vld, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_abort", abort, 0);
        rst = 1'b0;
        m_last = NREQ - 1;
`ifdef DATA_SCHED_STATS_EN
        for (int i = 0; i < NREQ; i++) stat_m[i] = 0;
`endif
        @(negedge clk);
        run_burst(4'b1111, -1, 1);

        for (int n = 0; n < 40; n++) begin
            run_burst(NREQ'($urandom_range(1, (1 << NREQ) - 1)),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, BURST - 1) : -1, 0);
        end

`ifdef DATA_SCHED_STATS_EN
        for (int n = 0; n < 300; n++) run_burst(4'b0001, -1, 1);
        for (int i = 0; i < NREQ; i++) begin
            check("gnt_cnt", gnt_cnt[i*8 +: 8], stat_m[i]);
        end
`endif

        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("exp_gnt_q_drained", exp_gnt_q.size(), 0);
        check("exp_end_q_drained", exp_end_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
